// File: rtl/rule_sched_pkg.sv
// Shared types and constants for the rule scheduler: mode encoding,
// LFSR feedback mask/seed and the step counter width.
package rule_sched_pkg;

  typedef enum logic {
    MODE_RR   = 1'b0,
    MODE_LFSR = 1'b1
  } mode_e;

  // Right-shifting Fibonacci form: feedback from bits 0,2,3,5 is the
  // x^16+x^14+x^13+x^11+1 polynomial (taps 16,14,13,11).
  localparam logic [15:0] LFSR_TAPS         = 16'h002D;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  localparam int STEP_W = 16;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/rule_sched_lfsr.sv
// 16-bit Fibonacci LFSR with enable; loads SEED on synchronous reset.
// SEED must be nonzero or the sequence locks at zero.
module rule_sched_lfsr
  import rule_sched_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_en,
  output logic [15:0] o_state
);

  logic [15:0] r_state;

  // Shift one position on every enabled cycle.
  always_ff @(posedge clock) begin
    if (reset)     r_state <= SEED;
    else if (i_en) r_state <= lfsr_next(r_state);
  end

  assign o_state = r_state;

endmodule

// File: rtl/rule_scheduler.sv
// Rule scheduler: picks one enabled rule instance per cycle for the
// Murphi-derived model. It scans the guard vector from a start index,
// round-robin by default. It bounds the trace length and flags deadlock.
// Define RULE_SCHEDULER_LFSR_EN to build the LFSR start index (io_mode=1).
// Without that macro, io_mode is ignored.
module rule_scheduler
  import rule_sched_pkg::*;
#(
  parameter int          NUM_RULES       = 6,
  parameter int          EN_W            = 3,
  parameter int          MAX_STEPS       = 1024,
  parameter int          DEADLOCK_CYCLES = 8,
  parameter logic [15:0] SEED            = LFSR_SEED_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_RULES-1:0] io_guard,
  input  logic                 io_hold,
  input  logic                 io_mode,
  output logic [EN_W-1:0]      io_en_a,
  output logic                 io_fire,
  output logic [STEP_W-1:0]    io_step,
  output logic                 io_done,
  output logic                 io_deadlock
);

  localparam int DL_W = $clog2(DEADLOCK_CYCLES + 1);

  logic [EN_W-1:0]   r_ptr;
  logic [STEP_W-1:0] r_step;
  logic              r_done;
  logic [DL_W-1:0]   r_dl_cnt;
  logic              r_deadlock;

  logic [EN_W-1:0]   w_start;
  logic [EN_W-1:0]   w_idx;
  logic [EN_W-1:0]   w_k;
  logic              w_found;
  logic              w_go;
  logic              w_any;

`ifdef RULE_SCHEDULER_LFSR_EN
  logic [15:0] w_lfsr;
  logic        w_unused_lfsr;

  // The LFSR free-runs whenever the scheduler is not held.
  rule_sched_lfsr #(.SEED(SEED)) u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .i_en    (!io_hold),
    .o_state (w_lfsr)
  );

  assign w_unused_lfsr = ^w_lfsr[15:EN_W];
  assign w_start = (mode_e'(io_mode) == MODE_LFSR)
                 ? EN_W'(int'(w_lfsr[EN_W-1:0]) % NUM_RULES)
                 : r_ptr;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{io_mode, SEED};
  assign w_start      = r_ptr;
`endif

  assign w_any = |io_guard;

  // Circular scan from w_start; the first true guard wins.
  always_comb begin
    w_found = 1'b0;
    w_k     = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_RULES; i++) begin
      w_idx = EN_W'((int'(w_start) + i) % NUM_RULES);
      if (!w_found && io_guard[w_idx]) begin
        w_found = 1'b1;
        w_k     = w_idx;
      end
    end
  end

  // Output is held quiet during reset. It idles on ptr when nothing can
  // fire, because a false-guard index is a no-op in the model.
  assign w_go    = w_found && !io_hold && !r_done && !reset;
  assign io_fire = w_go;
  assign io_en_a = reset ? '0 : (w_go ? w_k : r_ptr);

  // Fairness pointer and step budget advance only on a real fire.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr  <= '0;
      r_step <= '0;
      r_done <= 1'b0;
    end else if (w_go) begin
      r_ptr <= (w_k == EN_W'(NUM_RULES - 1)) ? '0 : w_k + 1'b1;
      if (r_step != STEP_W'(MAX_STEPS)) r_step <= r_step + 1'b1;
      if (r_step == STEP_W'(MAX_STEPS - 1)) r_done <= 1'b1;
    end
  end

  // Deadlock tracking keeps running after done; hold freezes it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_dl_cnt   <= '0;
      r_deadlock <= 1'b0;
    end else if (!io_hold) begin
      if (w_any) begin
        r_dl_cnt <= '0;
      end else begin
        if (r_dl_cnt != DL_W'(DEADLOCK_CYCLES)) r_dl_cnt <= r_dl_cnt + 1'b1;
        if (r_dl_cnt >= DL_W'(DEADLOCK_CYCLES - 1)) r_deadlock <= 1'b1;
      end
    end
  end

  assign io_step     = r_step;
  assign io_done     = r_done;
  assign io_deadlock = r_deadlock;

endmodule

// File: tb/tb_rule_scheduler.sv
// Directed bench for rule_scheduler. A vector table covers the main
// round-robin trace. Hand sequences cover the step budget and, when
// built with the LFSR macro, seeded random-mode replay.
module tb_rule_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] guard = '0;
  logic       hold = 1'b0;
  logic       mode = 1'b0;

  logic [2:0]  en_a,  en_a2;
  logic        fire,  fire2;
  logic [15:0] step,  step2;
  logic        done,  done2;
  logic        dl,    dl2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rule_scheduler #(.NUM_RULES(6), .EN_W(3), .MAX_STEPS(1024),
                   .DEADLOCK_CYCLES(8), .SEED(16'hACE1)) dut (
    .clock(clk), .reset(rst), .io_guard(guard), .io_hold(hold), .io_mode(mode),
    .io_en_a(en_a), .io_fire(fire), .io_step(step), .io_done(done),
    .io_deadlock(dl)
  );

  // Short-budget instance for the step-limit corner.
  rule_scheduler #(.NUM_RULES(6), .EN_W(3), .MAX_STEPS(3),
                   .DEADLOCK_CYCLES(8), .SEED(16'hACE1)) dut3 (
    .clock(clk), .reset(rst), .io_guard(guard), .io_hold(hold), .io_mode(mode),
    .io_en_a(en_a2), .io_fire(fire2), .io_step(step2), .io_done(done2),
    .io_deadlock(dl2)
  );

  typedef struct {
    logic        rst;
    logic        hold;
    logic [5:0]  guard;
    logic [2:0]  en;
    logic        fire;
    logic [15:0] step;
    logic        done;
    logic        dl;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic h, input logic [5:0] g,
                     input logic [2:0] e, input logic f, input logic [15:0] s,
                     input logic d, input logic l);
    vec_t v;
    v.rst = r; v.hold = h; v.guard = g; v.en = e;
    v.fire = f; v.step = s; v.done = d; v.dl = l;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] model_lfsr(input logic [15:0] s);
    logic b;
    b = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {b, s[15:1]};
  endfunction

  task automatic drive(input logic r, input logic h, input logic [5:0] g);
    @(negedge clk);
    rst = r; hold = h; guard = g;
    #1;
  endtask

`ifdef RULE_SCHEDULER_LFSR_EN
  logic [2:0] rec[12];
`endif

  initial begin
    // reset, then all guards true: 0,1,2,3,4,5,0
    add(1, 0, 6'h3F, 3'd0, 0, 16'd0, 0, 0);
    for (int i = 0; i < 7; i++) add(0, 0, 6'h3F, 3'(i % 6), 1, 16'(i), 0, 0);
    // steer ptr to 4, then the wrap scan on guards 0,1
    add(0, 0, 6'b001000, 3'd3, 1, 16'd7,  0, 0);
    add(0, 0, 6'b000011, 3'd0, 1, 16'd8,  0, 0);
    add(0, 0, 6'b000011, 3'd1, 1, 16'd9,  0, 0);
    add(0, 0, 6'b000011, 3'd0, 1, 16'd10, 0, 0);
    // 8 all-false cycles, deadlock shows after the 8th edge and is sticky
    for (int i = 0; i < 8; i++) add(0, 0, 6'h00, 3'd1, 0, 16'd11, 0, 0);
    add(0, 0, 6'h00, 3'd1, 0, 16'd11, 0, 1);
    add(0, 0, 6'h3F, 3'd1, 1, 16'd11, 0, 1);
    // hold for 5 cycles, then resume at held ptr
    for (int i = 0; i < 5; i++) add(0, 1, 6'h3F, 3'd2, 0, 16'd12, 0, 1);
    add(0, 0, 6'h3F, 3'd2, 1, 16'd12, 0, 1);
    // single true guard: same rule every cycle
    add(0, 0, 6'b100000, 3'd5, 1, 16'd13, 0, 1);
    add(0, 0, 6'b100000, 3'd5, 1, 16'd14, 0, 1);
    add(0, 1, 6'h00,     3'd0, 0, 16'd15, 0, 1);
    // reset mid-trace
    add(1, 0, 6'h3F,     3'd0, 0, 16'd15, 0, 1);
    add(0, 0, 6'h00,     3'd0, 0, 16'd0,  0, 0);
    add(0, 0, 6'b000100, 3'd2, 1, 16'd0,  0, 0);

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].rst, tv[i].hold, tv[i].guard);
      chk($sformatf("v%0d en_a", i), 32'(en_a), 32'(tv[i].en));
      chk($sformatf("v%0d fire", i), 32'(fire), 32'(tv[i].fire));
      chk($sformatf("v%0d step", i), 32'(step), 32'(tv[i].step));
      chk($sformatf("v%0d done", i), 32'(done), 32'(tv[i].done));
      chk($sformatf("v%0d deadlock", i), 32'(dl), 32'(tv[i].dl));
    end

    // step budget of 3: three fires, then done and no more fires
    drive(1, 0, 6'h3F);
    chk("budget reset fire", 32'(fire2), 32'd0);
    for (int c = 0; c < 5; c++) begin
      drive(0, 0, 6'h3F);
      chk($sformatf("budget c%0d fire", c), 32'(fire2), (c < 3) ? 32'd1 : 32'd0);
      chk($sformatf("budget c%0d step", c), 32'(step2), (c < 3) ? 32'(c) : 32'd3);
      chk($sformatf("budget c%0d done", c), 32'(done2), (c < 3) ? 32'd0 : 32'd1);
      chk($sformatf("budget c%0d en_a", c), 32'(en_a2), (c < 3) ? 32'(c) : 32'd3);
    end

`ifdef RULE_SCHEDULER_LFSR_EN
    // seeded random mode with a hold in the middle, then an exact replay
    begin
      logic [15:0] lf;
      int n;
      mode = 1'b1;
      for (int run = 0; run < 2; run++) begin
        drive(1, 0, 6'h3F);
        lf = 16'hACE1;
        n = 0;
        for (int c = 0; c < 12; c++) begin
          if (c == 4 || c == 5) begin
            drive(0, 1, 6'h3F);
            chk($sformatf("lfsr r%0d hold fire", run), 32'(fire), 32'd0);
          end else begin
            drive(0, 0, 6'h3F);
            if (run == 0 && n == 0)
              chk("lfsr first en_a", 32'(en_a), 32'd1);
            chk($sformatf("lfsr r%0d c%0d en_a", run, c), 32'(en_a),
                32'(lf[2:0] % 3'd6));
            if (run == 0) rec[n] = en_a;
            else chk($sformatf("lfsr replay c%0d", c), 32'(en_a), 32'(rec[n]));
            lf = model_lfsr(lf);
            n++;
          end
        end
      end
      mode = 1'b0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
